// File: rtl/move_decoder_pkg.sv
// Shared definitions for the maze move decoder: direction codes, FSM
// states, location field layout and default path endpoints.
package move_decoder_pkg;

  localparam logic [1:0] DIR_YDEC = 2'b00;
  localparam logic [1:0] DIR_XINC = 2'b01;
  localparam logic [1:0] DIR_XDEC = 2'b10;
  localparam logic [1:0] DIR_YINC = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_LOC = 3'd1,
    EMIT     = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } state_t;

  localparam int X_MSB = 7;
  localparam int X_LSB = 4;
  localparam int Y_MSB = 3;
  localparam int Y_LSB = 0;

  localparam logic [7:0] START_LOC_DEF = 8'h00;
  localparam logic [7:0] GOAL_LOC_DEF  = 8'hFF;
  localparam logic [7:0] MAX_STEPS_DEF = 8'd255;

  function automatic logic [3:0] loc_x(input logic [7:0] loc);
    return loc[X_MSB:X_LSB];
  endfunction

  function automatic logic [3:0] loc_y(input logic [7:0] loc);
    return loc[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/move_decoder_step_classifier.sv
// Combinational single-step check: decides whether loc_in is one legal
// move away from prev_loc and which direction code produced it.
module step_classifier
  import move_decoder_pkg::*;
(
  input  logic [7:0] prev_loc,
  input  logic [7:0] loc_in,
  output logic       legal,
  output logic [1:0] dir
);

  logic [3:0] px_s;
  logic [3:0] py_s;
  logic [3:0] lx_s;
  logic [3:0] ly_s;
  logic       legal_s;
  logic [1:0] dir_s;

  // Exactly one nibble moves by one; edge cells exclude the 4-bit wrap.
  always_comb begin
    px_s    = loc_x(prev_loc);
    py_s    = loc_y(prev_loc);
    lx_s    = loc_x(loc_in);
    ly_s    = loc_y(loc_in);
    legal_s = 1'b0;
    dir_s   = DIR_YDEC;
    if ((py_s == ly_s) && (px_s != 4'hF) && (lx_s == px_s + 4'd1)) begin
      legal_s = 1'b1;
      dir_s   = DIR_XINC;
    end else if ((py_s == ly_s) && (px_s != 4'h0) && (lx_s == px_s - 4'd1)) begin
      legal_s = 1'b1;
      dir_s   = DIR_XDEC;
    end else if ((px_s == lx_s) && (py_s != 4'hF) && (ly_s == py_s + 4'd1)) begin
      legal_s = 1'b1;
      dir_s   = DIR_YINC;
    end else if ((px_s == lx_s) && (py_s != 4'h0) && (ly_s == py_s - 4'd1)) begin
      legal_s = 1'b1;
      dir_s   = DIR_YDEC;
    end else begin
      legal_s = 1'b0;
      dir_s   = DIR_YDEC;
    end
  end

  assign legal = legal_s;
  assign dir   = dir_s;

endmodule

// File: rtl/move_decoder.sv
// Turns a stream of maze locations back into direction codes, validating
// each step, counting handed-off moves and flagging arrival at the goal.
module move_decoder
  import move_decoder_pkg::*;
#(
  parameter logic [7:0] START_LOC = START_LOC_DEF,
  parameter logic [7:0] GOAL_LOC  = GOAL_LOC_DEF,
  parameter logic [7:0] MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       locValid,
  input  logic [7:0] locIn,
  input  logic       locLast,
  output logic       locReady,
  output logic       dirValid,
  output logic [1:0] dir,
  input  logic       dirReady,
  output logic [7:0] stepCnt,
  output logic       busy,
  output logic       done,
  output logic       goalOk,
  output logic       err
);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] prev_loc_r;
  logic [7:0] prev_loc_s;
  logic [7:0] cur_loc_r;
  logic [7:0] cur_loc_s;
  logic       last_r;
  logic       last_s;
  logic [1:0] dir_r;
  logic [1:0] dir_s;
  logic [7:0] step_cnt_r;
  logic [7:0] step_cnt_s;

  logic       step_legal_s;
  logic [1:0] step_dir_s;

  logic       loc_ready_r;
  logic       loc_ready_s;
  logic       dir_valid_r;
  logic       dir_valid_s;
  logic       busy_r;
  logic       busy_s;
  logic       done_r;
  logic       done_s;
  logic       goal_ok_r;
  logic       goal_ok_s;
  logic       err_r;
  logic       err_s;

  step_classifier u_step_classifier (
    .prev_loc (prev_loc_r),
    .loc_in   (locIn),
    .legal    (step_legal_s),
    .dir      (step_dir_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      prev_loc_r <= START_LOC;
      cur_loc_r  <= START_LOC;
      last_r     <= 1'b0;
      dir_r      <= DIR_YDEC;
      step_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      prev_loc_r <= prev_loc_s;
      cur_loc_r  <= cur_loc_s;
      last_r     <= last_s;
      dir_r      <= dir_s;
      step_cnt_r <= step_cnt_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s    = state_r;
    prev_loc_s = prev_loc_r;
    cur_loc_s  = cur_loc_r;
    last_s     = last_r;
    dir_s      = dir_r;
    step_cnt_s = step_cnt_r;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_s    = WAIT_LOC;
          prev_loc_s = START_LOC;
          step_cnt_s = 8'd0;
        end else begin
          state_s = state_r;
        end
      end
      WAIT_LOC: begin
        // The step limit wins over classification: no step is taken past it.
        if (locValid) begin
          if (step_cnt_r == MAX_STEPS) begin
            state_s = ERROR;
          end else if (step_legal_s) begin
            state_s   = EMIT;
            dir_s     = step_dir_s;
            cur_loc_s = locIn;
            last_s    = locLast;
          end else begin
            state_s = ERROR;
          end
        end else begin
          state_s = WAIT_LOC;
        end
      end
      EMIT: begin
        if (dirReady) begin
          prev_loc_s = cur_loc_r;
          step_cnt_s = step_cnt_r + 8'd1;
          state_s    = last_r ? DONE : WAIT_LOC;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Flag values for the upcoming state, so the flags register with it.
  always_comb begin
    loc_ready_s = 1'b0;
    dir_valid_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    goal_ok_s   = 1'b0;
    err_s       = 1'b0;
    case (state_s)
      WAIT_LOC: begin
        loc_ready_s = 1'b1;
        busy_s      = 1'b1;
      end
      EMIT: begin
        dir_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      DONE: begin
        done_s    = 1'b1;
        goal_ok_s = (prev_loc_s == GOAL_LOC);
      end
      ERROR: begin
        err_s = 1'b1;
      end
      default: begin
        loc_ready_s = 1'b0;
      end
    endcase
  end

  // Output flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loc_ready_r <= 1'b0;
      dir_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      goal_ok_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      loc_ready_r <= loc_ready_s;
      dir_valid_r <= dir_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      goal_ok_r   <= goal_ok_s;
      err_r       <= err_s;
    end
  end

  assign locReady = loc_ready_r;
  assign dirValid = dir_valid_r;
  assign dir      = dir_r;
  assign stepCnt  = step_cnt_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign goalOk   = goal_ok_r;
  assign err      = err_r;

endmodule

// File: tb/tb_move_decoder.sv
// Directed, table-driven bench for move_decoder with hand-computed
// expectations and a few multi-cycle sequences for the corner cases.
module tb_move_decoder;

  logic       clk;
  logic       rst;
  logic       start;
  logic       locValid;
  logic [7:0] locIn;
  logic       locLast;
  logic       locReady;
  logic       dirValid;
  logic [1:0] dir;
  logic       dirReady;
  logic [7:0] stepCnt;
  logic       busy;
  logic       done;
  logic       goalOk;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] loc;
    logic       last;
    logic       exp_err;
    logic [1:0] exp_dir;
  } single_t;

  typedef struct {
    logic [7:0] loc;
    logic       last;
    logic [1:0] exp_dir;
    logic [7:0] exp_cnt;
  } path_t;

  single_t single_tbl[8];
  path_t   path_tbl[7];

  move_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .locValid (locValid),
    .locIn    (locIn),
    .locLast  (locLast),
    .locReady (locReady),
    .dirValid (dirValid),
    .dir      (dir),
    .dirReady (dirReady),
    .stepCnt  (stepCnt),
    .busy     (busy),
    .done     (done),
    .goalOk   (goalOk),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_loc(input logic [7:0] loc, input logic last);
    int n;
    n = 0;
    while (!locReady && n < 20) begin
      tick();
      n++;
    end
    chk("loc_ready_wait", {31'd0, locReady}, 32'd1);
    locValid = 1'b1;
    locIn    = loc;
    locLast  = last;
    tick();
    locValid = 1'b0;
    locLast  = 1'b0;
  endtask

  initial begin
    logic [7:0] cur;
    logic [1:0] edir;
    logic       need_start;
    int         bad;

    single_tbl[0] = '{8'h01, 1'b1, 1'b0, 2'b11};
    single_tbl[1] = '{8'h10, 1'b1, 1'b0, 2'b01};
    single_tbl[2] = '{8'h0F, 1'b1, 1'b1, 2'b00};
    single_tbl[3] = '{8'hF0, 1'b1, 1'b1, 2'b00};
    single_tbl[4] = '{8'h11, 1'b1, 1'b1, 2'b00};
    single_tbl[5] = '{8'h00, 1'b1, 1'b1, 2'b00};
    single_tbl[6] = '{8'h02, 1'b1, 1'b1, 2'b00};
    single_tbl[7] = '{8'h20, 1'b0, 1'b1, 2'b00};

    path_tbl[0] = '{8'h01, 1'b0, 2'b11, 8'd1};
    path_tbl[1] = '{8'h11, 1'b0, 2'b01, 8'd2};
    path_tbl[2] = '{8'h12, 1'b1, 2'b11, 8'd3};
    path_tbl[3] = '{8'h01, 1'b0, 2'b11, 8'd1};
    path_tbl[4] = '{8'h11, 1'b0, 2'b01, 8'd2};
    path_tbl[5] = '{8'h10, 1'b0, 2'b00, 8'd3};
    path_tbl[6] = '{8'h00, 1'b1, 2'b10, 8'd4};

    rst = 1'b0; start = 1'b0; locValid = 1'b0; locIn = 8'h00;
    locLast = 1'b0; dirReady = 1'b1;
    #12;
    chk("reset_state", {16'd0, locReady, dirValid, dir, stepCnt, busy, done, goalOk, err}, 32'd0);
    rst = 1'b1;
    tick();

    // Single-location paths from START_LOC.
    for (int i = 0; i < 8; i++) begin
      start_pulse();
      send_loc(single_tbl[i].loc, single_tbl[i].last);
      if (single_tbl[i].exp_err) begin
        chk("single_err", {29'd0, err, dirValid, busy}, 32'h4);
        chk("single_err_cnt", {24'd0, stepCnt}, 32'd0);
      end else begin
        chk("single_dir", {29'd0, dirValid, dir}, {29'd0, 1'b1, single_tbl[i].exp_dir});
        tick();
        chk("single_done", {23'd0, done, stepCnt}, {23'd0, 1'b1, 8'd1});
      end
    end

    // Multi-step paths, including the basic 01/11/12 path.
    need_start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (need_start) start_pulse();
      send_loc(path_tbl[i].loc, path_tbl[i].last);
      chk("path_dir", {29'd0, dirValid, dir}, {29'd0, 1'b1, path_tbl[i].exp_dir});
      tick();
      chk("path_cnt", {24'd0, stepCnt}, {24'd0, path_tbl[i].exp_cnt});
      if (path_tbl[i].last) chk("path_done", {30'd0, done, goalOk}, 32'h2);
      need_start = path_tbl[i].last;
    end

    // Staircase to the goal cell, 30 steps.
    start_pulse();
    cur = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        cur = cur + 8'h10;
        edir = 2'b01;
      end else begin
        cur = cur + 8'h01;
        edir = 2'b11;
      end
      send_loc(cur, (i == 29));
      chk("stair_dir", {29'd0, dirValid, dir}, {29'd0, 1'b1, edir});
      tick();
    end
    chk("stair_end", {22'd0, done, goalOk, stepCnt}, {22'd0, 1'b1, 1'b1, 8'd30});

    // Backpressure, with start and locValid offered while stalled.
    start_pulse();
    send_loc(8'h01, 1'b0);
    tick();
    dirReady = 1'b0;
    send_loc(8'h02, 1'b1);
    for (int k = 0; k < 5; k++) begin
      start    = (k == 2);
      locValid = 1'b1;
      locIn    = 8'h03;
      tick();
      chk("bp_hold", {20'd0, dirValid, dir, locReady, stepCnt}, {20'd0, 1'b1, 2'b11, 1'b0, 8'd1});
    end
    start = 1'b0;
    locValid = 1'b0;
    dirReady = 1'b1;
    tick();
    chk("bp_release", {22'd0, done, goalOk, stepCnt}, {22'd0, 1'b1, 1'b0, 8'd2});

    // Y+1 wrap from F is illegal.
    start_pulse();
    cur = 8'h00;
    for (int i = 0; i < 15; i++) begin
      cur = cur + 8'h01;
      send_loc(cur, 1'b0);
      tick();
    end
    send_loc(8'h00, 1'b0);
    chk("ywrap_err", {23'd0, err, stepCnt}, {23'd0, 1'b1, 8'd15});

    // Snake over all 256 cells reaches the step limit.
    start_pulse();
    cur = 8'h00;
    bad = 0;
    for (int s = 0; s < 255; s++) begin
      if (cur[4] == 1'b0) begin
        if (cur[3:0] != 4'hF) begin cur = cur + 8'h01; edir = 2'b11; end
        else begin cur = cur + 8'h10; edir = 2'b01; end
      end else begin
        if (cur[3:0] != 4'h0) begin cur = cur - 8'h01; edir = 2'b00; end
        else begin cur = cur + 8'h10; edir = 2'b01; end
      end
      send_loc(cur, 1'b0);
      if (!dirValid || dir !== edir) bad++;
      tick();
    end
    chk("snake_dirs", bad, 32'd0);
    chk("snake_cnt", {24'd0, stepCnt}, 32'd255);
    send_loc(8'hE0, 1'b0);
    chk("max_steps_err", {22'd0, err, dirValid, stepCnt}, {22'd0, 1'b1, 1'b0, 8'd255});

    // Illegal wrap step is sticky until start.
    start_pulse();
    send_loc(8'h0F, 1'b0);
    chk("illegal_err", {22'd0, err, dirValid, stepCnt}, {22'd0, 1'b1, 1'b0, 8'd0});
    for (int k = 0; k < 3; k++) begin
      locValid = 1'b1;
      locIn = 8'h01;
      tick();
      chk("err_sticky", {30'd0, err, busy}, 32'h2);
    end
    locValid = 1'b0;
    start_pulse();
    chk("err_cleared", {30'd0, err, busy}, 32'h1);
    send_loc(8'h01, 1'b1);
    tick();
    chk("after_err_done", {31'd0, done}, 32'd1);

    // Reset mid-EMIT, then restart.
    start_pulse();
    send_loc(8'h01, 1'b0);
    tick();
    dirReady = 1'b0;
    send_loc(8'h02, 1'b0);
    chk("pre_reset", {23'd0, dirValid, stepCnt}, {23'd0, 1'b1, 8'd1});
    #2 rst = 1'b0;
    #1 chk("async_reset", {22'd0, dirValid, busy, stepCnt}, 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("post_reset_idle", {28'd0, busy, done, err, dirValid}, 32'd0);
    dirReady = 1'b1;
    start_pulse();
    send_loc(8'h10, 1'b1);
    chk("restart_dir", {29'd0, dirValid, dir}, {29'd0, 1'b1, 2'b01});
    tick();
    chk("restart_done", {23'd0, done, stepCnt}, {23'd0, 1'b1, 8'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
